// File: rtl/fadd_arbiter.sv
// fadd_arbiter: round-robin two-port front end for one shared single-precision adder.
// Ports: clk, rstn (async active-low); req0/req1 valid/ready + s,t,tag in;
// resp0/resp1 valid/ready + d,tag,ovf out; ovf_clr in / ovf_sticky out.
// Optional: define FADD_ARB_STICKY_OVF_EN to build the sticky overflow flag.
module fadd (
  input  logic [31:0] s,
  input  logic [31:0] t,
  output logic [31:0] d,
  output logic        ovf
);
  logic [31:0] x, y;
  logic        sub, lost, rnd, hid, x_nan, x_inf, y_inf;
  logic [7:0]  ex, ey, diff;
  logic [23:0] mx, my;
  logic [26:0] ya, m;
  logic [27:0] sum;
  logic [24:0] mr;
  logic [9:0]  e, sh, e_n, e_r;
  logic [4:0]  lz;
  always_comb begin
    // x is always the operand of larger magnitude, so it sets sign and exponent
    x = (s[30:0] >= t[30:0]) ? s : t;
    y = (s[30:0] >= t[30:0]) ? t : s;
    ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx = {x[30:23] != 8'd0, x[22:0]};
    my = {y[30:23] != 8'd0, y[22:0]};
    diff = ex - ey;
    ya = {my, 3'b000} >> diff;
    lost = (ya << diff) != {my, 3'b000};
    sub = x[31] ^ y[31];
    sum = sub ? {1'b0, mx, 3'b000} - {1'b0, ya[26:1], ya[0] | lost}
              : {1'b0, mx, 3'b000} + {1'b0, ya[26:1], ya[0] | lost};
    lz = 5'd27;
    for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
    e = {2'b00, ex};
    // left shift stops at exponent 1 so tiny results land as denormals
    sh = ({5'd0, lz} < e - 10'd1) ? {5'd0, lz} : e - 10'd1;
    m = sum[27] ? {sum[27:2], sum[1] | sum[0]} : sum[26:0] << sh;
    e_n = sum[27] ? e + 10'd1 : e - sh;
    rnd = m[2] & (m[1] | m[0] | m[3]);
    mr = {1'b0, m[26:3]} + {24'd0, rnd};
    e_r = mr[24] ? e_n + 10'd1 : e_n;
    hid = mr[24] | mr[23];
    x_nan = (x[30:23] == 8'hFF) & (x[22:0] != 23'd0);
    x_inf = x[30:0] == 31'h7F800000;
    y_inf = y[30:0] == 31'h7F800000;
    ovf = (x[30:23] != 8'hFF) & (e_r >= 10'd255);
    d = (x_nan | (x_inf & y_inf & sub)) ? 32'h7FC00000 :
        x_inf                           ? x :
        ovf                             ? {x[31], 8'hFF, 23'd0} :
        (sum == 28'd0)                  ? {x[31] & y[31], 31'd0} :
                                          {x[31], hid ? e_r[7:0] : 8'd0, mr[24] ? 23'd0 : mr[22:0]};
  end
endmodule

module fadd_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_s,
  input  logic [31:0]      req0_t,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_s,
  input  logic [31:0]      req1_t,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [31:0]      resp0_d,
  output logic [TAG_W-1:0] resp0_tag,
  output logic             resp0_ovf,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [31:0]      resp1_d,
  output logic [TAG_W-1:0] resp1_tag,
  output logic             resp1_ovf,
  input  logic             ovf_clr,
  output logic             ovf_sticky
);
  logic             a_vld_q, a_vld_d, a_own_q, a_own_d, b_vld_q, b_vld_d, b_own_q, b_own_d;
  logic             b_ovf_q, b_ovf_d, prio_q, prio_d;
  logic [31:0]      a_s_q, a_s_d, a_t_q, a_t_d, b_d_q, b_d_d, sum;
  logic [TAG_W-1:0] a_tag_q, a_tag_d, b_tag_q, b_tag_d;
  logic             sum_ovf, b_free, a_adv, a_free, acc0, acc1;
  fadd u_fadd (.s(a_s_q), .t(a_t_q), .d(sum), .ovf(sum_ovf));
  always_comb begin
    b_free = !b_vld_q | (b_own_q ? resp1_ready : resp0_ready);
    a_adv = a_vld_q & b_free;
    a_free = !a_vld_q | a_adv;
    // readiness looks only at the other port's valid; rstn gates it while in reset
    req0_ready = rstn & a_free & (!req1_valid | !prio_q);
    req1_ready = rstn & a_free & (!req0_valid | prio_q);
    acc0 = req0_valid & req0_ready;
    acc1 = req1_valid & req1_ready;
    a_vld_d = acc0 | acc1 | (a_vld_q & !a_adv);
    a_own_d = (acc0 | acc1) ? acc1 : a_own_q;
    a_s_d = acc1 ? req1_s : acc0 ? req0_s : a_s_q;
    a_t_d = acc1 ? req1_t : acc0 ? req0_t : a_t_q;
    a_tag_d = acc1 ? req1_tag : acc0 ? req0_tag : a_tag_q;
    prio_d = (acc0 | acc1) ? acc0 : prio_q;
    b_vld_d = a_adv | (b_vld_q & !b_free);
    b_own_d = a_adv ? a_own_q : b_own_q;
    b_d_d = a_adv ? sum : b_d_q;
    b_tag_d = a_adv ? a_tag_q : b_tag_q;
    b_ovf_d = a_adv ? sum_ovf : b_ovf_q;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      a_vld_q <= 1'b0;
      a_own_q <= 1'b0;
      a_s_q <= '0;
      a_t_q <= '0;
      a_tag_q <= '0;
      b_vld_q <= 1'b0;
      b_own_q <= 1'b0;
      b_d_q <= '0;
      b_tag_q <= '0;
      b_ovf_q <= 1'b0;
      prio_q <= 1'b0;
    end else begin
      a_vld_q <= a_vld_d;
      a_own_q <= a_own_d;
      a_s_q <= a_s_d;
      a_t_q <= a_t_d;
      a_tag_q <= a_tag_d;
      b_vld_q <= b_vld_d;
      b_own_q <= b_own_d;
      b_d_q <= b_d_d;
      b_tag_q <= b_tag_d;
      b_ovf_q <= b_ovf_d;
      prio_q <= prio_d;
    end
  assign resp0_valid = b_vld_q & !b_own_q;
  assign resp1_valid = b_vld_q & b_own_q;
  assign resp0_d = b_d_q;
  assign resp1_d = b_d_q;
  assign resp0_tag = b_tag_q;
  assign resp1_tag = b_tag_q;
  assign resp0_ovf = b_ovf_q;
  assign resp1_ovf = b_ovf_q;
`ifdef FADD_ARB_STICKY_OVF_EN
  logic ovf_sticky_q, ovf_sticky_d;
  // set on the edge stage B captures an overflowing result; set beats clear
  assign ovf_sticky_d = (a_adv & sum_ovf) | (ovf_sticky_q & !ovf_clr);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) ovf_sticky_q <= 1'b0;
    else ovf_sticky_q <= ovf_sticky_d;
  assign ovf_sticky = ovf_sticky_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_fadd_arbiter.sv
// tb_fadd_arbiter: scenario tasks plus a transaction-level scoreboard for fadd_arbiter.
module tb_fadd_arbiter;
  localparam int TW = 4;
`ifdef FADD_ARB_STICKY_OVF_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif
  // {s, t, expected d, expected overflow}; operands may be presented in either order
  localparam logic [96:0] TBL [12] = '{
    {32'h3F800000, 32'h40000000, 32'h40400000, 1'b0},
    {32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1},
    {32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0},
    {32'h40A00000, 32'hC0400000, 32'h40000000, 1'b0},
    {32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0},
    {32'h3FC00000, 32'h3FC00000, 32'h40400000, 1'b0},
    {32'h41200000, 32'h3F000000, 32'h41280000, 1'b0},
    {32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0},
    {32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0},
    {32'h00000001, 32'h00000001, 32'h00000002, 1'b0},
    {32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1},
    {32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0}
  };

  logic clk = 1'b0, rstn = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, resp0_ready = 1'b0, resp1_ready = 1'b0, ovf_clr = 1'b0;
  logic [31:0] req0_s = '0, req0_t = '0, req1_s = '0, req1_t = '0;
  logic [TW-1:0] req0_tag = '0, req1_tag = '0;
  logic req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_ovf, resp1_ovf, ovf_sticky;
  logic [31:0] resp0_d, resp1_d;
  logic [TW-1:0] resp0_tag, resp1_tag;

  int n_checks = 0, n_errors = 0, n_resp = 0;

  typedef struct packed {logic own; logic [TW-1:0] tag; logic [31:0] d; logic ovf;} exp_t;
  exp_t q[$];
  logic m_prio = 1'b0;

  fadd_arbiter #(.TAG_W(TW)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_s(req0_s), .req0_t(req0_t), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_s(req1_s), .req1_t(req1_t), .req1_tag(req1_tag),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_d(resp0_d), .resp0_tag(resp0_tag), .resp0_ovf(resp0_ovf),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_d(resp1_d), .resp1_tag(resp1_tag), .resp1_ovf(resp1_ovf),
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] ref_fadd(input logic [31:0] s, input logic [31:0] t);
    logic [96:0] e;
    ref_fadd = '0;
    for (int i = 0; i < 12; i++) begin
      e = TBL[i];
      if ((e[96:65] == s && e[64:33] == t) || (e[96:65] == t && e[64:33] == s)) ref_fadd = {1'b1, e[32:0]};
    end
  endfunction

  // Scoreboard: accepted operations form one in-order stream; each must come back once, on its own port.
  always @(negedge clk) begin : mon
    exp_t e;
    logic [33:0] r;
    logic a0, a1, rv, rr;
    if (!rstn) begin
      q.delete();
      m_prio = 1'b0;
    end else begin
      n_checks++;
      if (resp0_valid && resp1_valid) begin n_errors++; $display("FAIL resp_excl both resp valid"); end
      for (int p = 0; p < 2; p++) begin
        rv = p ? resp1_valid : resp0_valid;
        rr = p ? resp1_ready : resp0_ready;
        if (rv && rr) begin
          n_checks++;
          if (q.size() == 0) begin
            n_errors++; $display("FAIL resp_extra port %0d got d=%h nothing outstanding", p, p ? resp1_d : resp0_d);
          end else begin
            e = q.pop_front();
            n_resp++;
            if (e.own !== 1'(p) || (p ? resp1_d : resp0_d) !== e.d || (p ? resp1_tag : resp0_tag) !== e.tag ||
                (p ? resp1_ovf : resp0_ovf) !== e.ovf) begin
              n_errors++;
              $display("FAIL resp port=%0d d=%h tag=%h ovf=%b expected port=%0d d=%h tag=%h ovf=%b", p,
                       p ? resp1_d : resp0_d, p ? resp1_tag : resp0_tag, p ? resp1_ovf : resp0_ovf, e.own, e.d, e.tag, e.ovf);
            end
          end
        end
      end
      a0 = req0_valid & req0_ready;
      a1 = req1_valid & req1_ready;
      n_checks++;
      if (a0 && a1) begin n_errors++; $display("FAIL grant_excl both accepted"); end
      if (req0_valid && req1_valid && (a0 || a1)) begin
        n_checks++;
        if (a1 !== m_prio) begin n_errors++; $display("FAIL rr_winner got %0d expected %0d", a1, m_prio); end
      end
      if (a0 || a1) begin
        r = a1 ? ref_fadd(req1_s, req1_t) : ref_fadd(req0_s, req0_t);
        e.own = a1;
        e.tag = a1 ? req1_tag : req0_tag;
        e.d = r[32:1];
        e.ovf = r[0];
        q.push_back(e);
        m_prio = a0;
      end
      n_checks++;
      if (q.size() > 2) begin n_errors++; $display("FAIL occupancy got %0d expected <=2", q.size()); end
    end
  end

  task automatic set_req(input int p, input int idx, input bit swap, input logic [TW-1:0] tag);
    logic [96:0] e;
    e = TBL[idx];
    if (p == 0) begin
      req0_valid = 1'b1; req0_s = swap ? e[64:33] : e[96:65]; req0_t = swap ? e[96:65] : e[64:33]; req0_tag = tag;
    end else begin
      req1_valid = 1'b1; req1_s = swap ? e[64:33] : e[96:65]; req1_t = swap ? e[96:65] : e[64:33]; req1_tag = tag;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic idle(input int n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0) begin
      n_errors++; $display("FAIL reset_hs got %b expected 0000", {req0_ready, req1_ready, resp0_valid, resp1_valid});
    end
    n_checks++;
    if ({resp0_d, resp1_d, resp0_tag, resp1_tag, resp0_ovf, resp1_ovf, ovf_sticky} !== '0) begin
      n_errors++; $display("FAIL reset_data got d0=%h d1=%h tag0=%h tag1=%h sticky=%b expected 0", resp0_d, resp1_d, resp0_tag, resp1_tag, ovf_sticky);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_single_op();
    do_reset();
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    set_req(0, 0, 1'b0, 4'd3);
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b1 || resp0_valid !== 1'b0) begin
      n_errors++; $display("FAIL single_accept got ready=%b resp=%b expected 1 0", req0_ready, resp0_valid);
    end
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (resp0_valid !== 1'b0) begin n_errors++; $display("FAIL single_early got resp0_valid=%b expected 0", resp0_valid); end
    @(negedge clk);
    n_checks++;
    if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || resp0_d !== 32'h40400000 || resp0_tag !== 4'd3 || resp0_ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL single_resp got v0=%b v1=%b d=%h tag=%h ovf=%b expected 1 0 40400000 3 0", resp0_valid, resp1_valid, resp0_d, resp0_tag, resp0_ovf);
    end
    idle(2);
  endtask

  task automatic test_contention();
    int base;
    do_reset();
    base = n_resp;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_req(0, $urandom_range(0, 11), 1'($urandom_range(0, 1)), 4'(k));
      set_req(1, $urandom_range(0, 11), 1'($urandom_range(0, 1)), 4'(k + 8));
      @(negedge clk);
      n_checks++;
      if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
        n_errors++; $display("FAIL contention_grant cycle %0d got ready0=%b ready1=%b expected %0d %0d", k, req0_ready, req1_ready, k % 2 == 0, k % 2 == 1);
      end
      @(posedge clk);
      #1;
    end
    idle(4);
    n_checks++;
    if (n_resp - base != 8) begin n_errors++; $display("FAIL contention_count got %0d expected 8", n_resp - base); end
  endtask

  task automatic test_backpressure();
    int base;
    logic [31:0] held;
    do_reset();
    base = n_resp;
    held = '0;
    resp0_ready = 1'b0;
    resp1_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      set_req(0, 6, 1'b0, 4'(k));
      set_req(1, 3, 1'b1, 4'(k + 7));
      @(negedge clk);
      if (k == 2) held = resp0_d;
      if (k >= 2) begin
        n_checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || resp0_valid !== 1'b1 || resp0_d !== held) begin
          n_errors++;
          $display("FAIL bp_hold cycle %0d got r0=%b r1=%b v0=%b d=%h expected 0 0 1 %h", k, req0_ready, req1_ready, resp0_valid, resp0_d, held);
        end
      end
      @(posedge clk);
      #1;
    end
    idle(6);
    n_checks++;
    if (n_resp - base != 2 || q.size() != 0) begin
      n_errors++; $display("FAIL bp_drain got %0d left %0d expected 2 0", n_resp - base, q.size());
    end
  endtask

  task automatic test_overflow();
    logic ok;
    do_reset();
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    set_req(1, 1, 1'b0, 4'd5);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 8 && !ok; k++) begin @(negedge clk); ok = resp1_valid; end
    n_checks++;
    if (!ok || resp1_d !== 32'h7F800000 || resp1_ovf !== 1'b1 || resp1_tag !== 4'd5 || ovf_sticky !== STICKY) begin
      n_errors++;
      $display("FAIL ovf_resp got v=%b d=%h ovf=%b tag=%h sticky=%b expected 1 7f800000 1 5 %b", ok, resp1_d, resp1_ovf, resp1_tag, ovf_sticky, STICKY);
    end
    @(posedge clk);
    #1 set_req(0, 0, 1'b0, 4'd6);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ovf_sticky !== STICKY) begin n_errors++; $display("FAIL ovf_hold got %b expected %b", ovf_sticky, STICKY); end
    @(posedge clk);
    #1 ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    n_checks++;
    if (ovf_sticky !== 1'b0) begin n_errors++; $display("FAIL ovf_clear got %b expected 0", ovf_sticky); end
    idle(2);
  endtask

  task automatic test_midflight_reset();
    do_reset();
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    set_req(0, 5, 1'b0, 4'd1);
    set_req(1, 4, 1'b0, 4'd2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (resp0_valid !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_errors++; $display("FAIL mid_full got v0=%b r0=%b r1=%b expected 1 0 0", resp0_valid, req0_ready, req1_ready);
    end
    #1 rstn = 1'b0;
    #1;
    n_checks++;
    if ({resp0_valid, resp1_valid, req0_ready, req1_ready} !== 4'b0) begin
      n_errors++; $display("FAIL mid_reset got %b expected 0000", {resp0_valid, resp1_valid, req0_ready, req1_ready});
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_errors++; $display("FAIL mid_first_grant got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
    end
    @(posedge clk);
    #1;
    idle(4);
  endtask

  task automatic test_nan_inf();
    logic ok;
    do_reset();
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    set_req(1, 2, 1'b0, 4'd9);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 8 && !ok; k++) begin @(negedge clk); ok = resp1_valid; end
    n_checks++;
    if (!ok || resp1_d !== 32'h7FC00000 || resp1_tag !== 4'd9 || resp0_valid !== 1'b0) begin
      n_errors++; $display("FAIL nan_resp got v=%b d=%h tag=%h v0=%b expected 1 7fc00000 9 0", ok, resp1_d, resp1_tag, resp0_valid);
    end
    idle(2);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if ($urandom_range(0, 2) != 0) set_req(0, $urandom_range(0, 11), 1'($urandom_range(0, 1)), 4'($urandom));
      if ($urandom_range(0, 2) != 0) set_req(1, $urandom_range(0, 11), 1'($urandom_range(0, 1)), 4'($urandom));
      resp0_ready = $urandom_range(0, 3) != 0;
      resp1_ready = $urandom_range(0, 3) != 0;
      @(posedge clk);
      #1;
    end
    idle(1);
    for (int k = 0; k < 20 && q.size() != 0; k++) begin @(posedge clk); #1; end
    n_checks++;
    if (q.size() != 0) begin n_errors++; $display("FAIL random_drain got %0d outstanding expected 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_overflow();
    test_midflight_reset();
    test_nan_inf();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
